// File: rtl/lsu_bus_master_if.sv
// Data-memory bus bundle: word address, byte enables, write data,
// req/gnt request handshake and rvalid response.
interface lsu_bus_master_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one command at a time from the core, alignment and
// funct3 checks, req/gnt + rvalid bus handshake, load extension, timeout.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [1:0]  lsu_err_code,
  output logic [31:0] lsu_rdata,
  lsu_bus_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_e;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  code_q, code_d;
  logic [9:0]  cnt_q, cnt_d;

  logic        illegal_f3;
  logic        misaligned;
  logic [3:0]  be_c;
  logic [31:0] wrep_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_c;

  // Command legality of the incoming request (illegal funct3 outranks misalignment)
  always_comb begin
    illegal_f3 = lsu_we ? (lsu_funct3 > 3'd2)
                        : (lsu_funct3 == 3'd3 || lsu_funct3 == 3'd6 || lsu_funct3 == 3'd7);
    misaligned = (lsu_funct3[1:0] == 2'd1 && lsu_addr[0]) ||
                 (lsu_funct3[1:0] == 2'd2 && lsu_addr[1:0] != 2'b00);
  end

  // Byte enables, replicated store data and extended load data from the captured command
  always_comb begin
    case (f3_q[1:0])
      2'd0:    be_c = 4'b0001 << addr_q[1:0];
      2'd1:    be_c = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
    case (f3_q[1:0])
      2'd0:    wrep_c = {4{wdata_q[7:0]}};
      2'd1:    wrep_c = {2{wdata_q[15:0]}};
      default: wrep_c = wdata_q;
    endcase
    byte_sel = bus.bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_c = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_c = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_c = {24'h0, byte_sel};
      3'b101:  load_c = {16'h0, half_sel};
      default: load_c = bus.bus_rdata;
    endcase
  end

  // Next-state logic: command capture, handshake progress, timeout abort
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        code_d = '0;
        if (lsu_req) begin
          we_d    = lsu_we;
          f3_d    = lsu_funct3;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          cnt_d   = '0;
          if (illegal_f3 || misaligned) begin
            code_d  = illegal_f3 ? 2'b10 : 2'b01;
            state_d = S_DONE;
            if (!lsu_we) rdata_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 10'd1;
        if (cnt_q == CNT_LAST) begin
          code_d  = 2'b11;
          state_d = S_DONE;
          if (!we_q) rdata_d = '0;
        end else if (bus.bus_gnt) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        cnt_d = cnt_q + 10'd1;
        // A response in the last allowed cycle still completes the access
        if (bus.bus_rvalid) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = load_c;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = 2'b11;
          state_d = S_DONE;
          if (!we_q) rdata_d = '0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Core-side and bus-side outputs; bus fields are zero outside REQ
  always_comb begin
    lsu_busy      = (state_q != S_IDLE);
    lsu_done      = (state_q == S_DONE);
    lsu_err       = lsu_done && (code_q != 2'b00);
    lsu_err_code  = lsu_done ? code_q : '0;
    lsu_rdata     = rdata_q;
    bus.bus_req   = (state_q == S_REQ);
    bus.bus_we    = bus.bus_req && we_q;
    bus.bus_addr  = bus.bus_req ? {addr_q[31:2], 2'b00} : '0;
    bus.bus_be    = bus.bus_req ? be_c : '0;
    bus.bus_wdata = (bus.bus_req && we_q) ? wrep_c : '0;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store initiator between the single-cycle core's execute stage and the word-organised data memory bus.
- Accepts one load or store command from the core at a time.
- Checks alignment, builds the word-aligned address, byte enables and lane-replicated write data, and drives a req/gnt + rvalid handshake.
- Extracts and sign- or zero-extends load data, and reports completion or error back to the core.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed from entering REQ until rvalid. When it expires, the access is aborted with a timeout error. Valid range 1..1023.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- lsu_req  in  1  command valid; sampled only in IDLE.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- lsu_addr  in  32  byte address.
- lsu_wdata  in  32  store data (rs2).
- lsu_busy  out  1  high whenever state != IDLE.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_err  out  1  valid with lsu_done; access failed.
- lsu_err_code  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout.
- lsu_rdata  out  32  extended load result.
- bus_req  out  1  request valid.
- bus_we  out  1  write request.
- bus_addr  out  32  equals {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  response valid; read data for loads, write ack for stores.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; timeout counter = 0; all outputs 0.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - On lsu_req, capture we, funct3, addr and wdata into registers.
  - Illegal funct3 (loads 011/110/111; stores 011 and above) -> DONE with code 10.
  - Misaligned (H with addr[0] = 1; W with addr[1:0] != 0) -> DONE with code 01.
  - An illegal funct3 takes priority over misalignment.
  - On an error, no bus_req is ever raised.
  - Otherwise -> REQ.
- REQ:
  - bus_req = 1; bus_we, bus_addr, bus_be and bus_wdata are driven from the captured registers and stay stable until gnt.
  - bus_gnt = 1 -> RSP; bus_req drops the following cycle.
- RSP:
  - Wait for bus_rvalid, which is sampled only in this state; rvalid seen in IDLE or REQ is ignored.
  - On rvalid -> DONE. For a load, lsu_rdata is registered from bus_rdata in the same edge.
- DONE:
  - lsu_done = 1 for exactly one cycle, then -> IDLE.
  - lsu_err and lsu_err_code are valid only while lsu_done = 1; they are 0 otherwise.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or RSP.
  - When the counter reaches TIMEOUT_CYCLES -> DONE with code 11, and bus_req is deasserted immediately.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
  - Loads drive the same pattern for information only.
- Write data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
  - bus_wdata = 0 for loads.
- Load extraction:
  - The byte or halfword is selected by addr[1:0] / addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- lsu_rdata update rules:
  - Updated only when a load completes successfully; otherwise it holds its value.
  - Cleared to 0 on a load error.
  - Stores never modify it.
- lsu_req while busy is ignored; the core must hold off until lsu_done.
- Back-to-back commands: a new lsu_req can be accepted in the IDLE cycle following DONE.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the first RSP cycle:
  - accept at cycle 0;
  - REQ at cycle 1;
  - RSP at cycle 2;
  - lsu_done at cycle 3.
- Reset asserted mid-transaction aborts without a done pulse. The bus must discard any pending response.

Test Plan:
- LW addr 0x0000_0008, gnt immediate, rvalid next cycle with 0x8765_4321 -> bus_addr 0x08, bus_be 1111, lsu_done at cycle 3, lsu_rdata 0x8765_4321, err 0.
- LB addr 0x13, rdata 0x80FF_7F01 -> bus_addr 0x10, be 1000, lsu_rdata 0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
- SH addr 0x06, wdata 0x1234_ABCD -> bus_we 1, bus_be 1100, bus_wdata 0xABCD_ABCD. lsu_done follows rvalid; lsu_rdata is unchanged.
- LW addr 0x0A -> no bus_req; lsu_done at cycle 1 with err 1, code 01. Store funct3 100 -> code 10.
- gnt withheld for 3 cycles, then rvalid after 2 more cycles -> bus_req stays high with stable fields; lsu_done at cycle 7. A stray rvalid during REQ is ignored.
- TIMEOUT_CYCLES = 4, never gnt -> bus_req drops after 4 cycles; lsu_done with code 11. Reset asserted in RSP -> all outputs go to 0 asynchronously, state IDLE, no lsu_done.
